imem_program_loader: RTL
========================

# imem_program_loader

Sequential instruction encoder and loader for the RISC-V pipeline's instruction memory. Accepts decoded instruction fields (encoding type, opcode, funct3/funct7, register indices, 32-bit immediate) over a valid/ready stream. Packs each beat into a 32-bit instruction word as the exact inverse of the pipeline's immediate extension. Writes the words to consecutive instruction-memory addresses starting at 0, and is used to build programs for the core.

## Interface
- ADDR_WIDTH, 5, instruction-memory word address width; DEPTH = 2**ADDR_WIDTH words
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin a new load at address 0
- finish  in  1  pulse: end load after any pending write
- in_valid / in_ready  in / out  1 / 1  field-beat handshake
- in_encoding  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6,7 illegal
- in_opcode  in  7;  in_funct3  in  3;  in_funct7  in  7;  in_rd, in_rs1, in_rs2  in  5 each
- in_imm  in  32  immediate value (already sign-extended)
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  ADDR_WIDTH  write address
- imem_wdata  out  32  encoded instruction
- busy  out  1  state is LOAD
- done  out  1  state is DONE
- words_written  out  ADDR_WIDTH+1  words written since start
- enc_err  out  1  sticky: illegal encoding seen
- range_err  out  1  sticky: immediate out of range for its type

## Operation
- States: IDLE, LOAD, DONE. Reset → IDLE.
- IDLE→LOAD on start. Entering LOAD clears the address counter, words_written, enc_err and range_err.
- start is ignored in LOAD.
- DONE→LOAD on start (restart). finish is ignored outside LOAD.
- in_ready = LOAD && accepted < DEPTH && !finish_seen. It is combinational from state only and never depends on in_valid.
- Accepting a beat (in_valid && in_ready) registers the encoded word. The write occurs the next cycle.
- Field packing (bit 31 down to 0):
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B (team mapping, inverse of decoder): [31]=imm[11], [30:25]=imm[9:4], rs2, rs1, funct3, [11:8]=imm[3:0], [7]=imm[10], opcode.
  - U: imm[31:12], rd, opcode.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], rd, opcode.
- Range rules:
  - I/S/B: imm must lie in −2048..2047.
  - U: imm[11:0] must be 0.
  - J: imm must lie in −2^20..2^20−1 and be even.
  - On violation, set range_err and still write the truncated word.
- Illegal encoding (6/7): the beat is consumed, enc_err is set, nothing is written, and the address does not advance.
- The address counter increments after each write; words_written tracks the count.
- LOAD→DONE when no write is pending and either (finish_seen) or (accepted == DEPTH).
- Round-trip requirement: for every in-range I/S/B immediate, decoding the written word with the pipeline's immediate extension returns in_imm.

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, words_written=0, enc_err=0, range_err=0.
- Latency: beat accepted at edge N → imem_we=1 with its addr/wdata during cycle N+1.
- Throughput: one word per cycle with in_valid held high.
- start at edge N → busy=1 and in_ready=1 from cycle N+1.
- finish coincident with an accepted beat: that beat is written. done=1 the cycle after its write.
- finish with nothing pending: done=1 the next cycle.
- Full: after the DEPTH-th accept, in_ready=0 next cycle. Last write at addr DEPTH−1; done the following cycle; words_written=DEPTH. The address does not wrap into a 33rd write.
- Reset mid-LOAD: immediate return to IDLE; the pending write is discarded (no imem_we after reset asserts).

## Test plan
- Reset: hold reset_n=0 → all outputs 0. Release, no start → in_ready stays 0.
- start, then I-type (opcode 0x13, funct3 0, rd 1, rs1 0, imm 0xFFFFFFFF) → next cycle imem_we=1, addr 0, wdata 0xFFF00093.
- Back-to-back beats:
  - R-type (funct7 0, rs2 2, rs1 1, funct3 0, rd 3, opcode 0x33) → addr 0 wdata 0x002081B3.
  - S-type (opcode 0x23, funct3 2, rs1 1, rs2 2, imm 8) → addr 1 wdata 0x0020A423, in consecutive cycles.
- B-type (opcode 0x63, funct3 0, rs1 0, rs2 0, imm 0xFFFFFFFC) → wdata 0xFE000CE3; immediate extension of that word returns 0xFFFFFFFC.
- Errors:
  - encoding 7 → enc_err=1, no imem_we, next legal word at unchanged addr.
  - I-type imm 4096 → range_err=1, word written with imm field 0.
- Fill and finish:
  - 32 continuous beats (ADDR_WIDTH=5) → addrs 0..31, in_ready=0 after 32nd accept, done=1, words_written=32.
  - Separately, finish with a coincident beat → that beat is written, then done.
  - reset_n pulse mid-stream → no further writes.

Source files
------------

// File: rtl/imem_program_loader.sv
// Encodes decoded RISC-V instruction fields into 32-bit words and writes them
// to consecutive instruction-memory addresses, starting at 0 on each load.
module imem_program_loader #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  finish,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_encoding,
    input  logic [6:0]            in_opcode,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [31:0]           in_imm,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic                  enc_err,
    output logic                  range_err
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    typedef enum logic [2:0] {
        ENC_R = 3'd0, ENC_I = 3'd1, ENC_S = 3'd2,
        ENC_B = 3'd3, ENC_U = 3'd4, ENC_J = 3'd5
    } enc_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH:0]   accepted;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  finish_seen;
    logic                  we_q;
    logic [31:0]           wdata_q;
    logic                  enc_err_q;
    logic                  range_err_q;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        range_bad;
    logic        fits12;
    logic        fits21;
    logic        accept;
    logic        write_new;
    logic        start_load;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        range_bad = 1'b0;
        fits12    = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
        fits21    = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);
        case (in_encoding)
            ENC_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            ENC_I: begin
                enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                range_bad = !fits12;
            end
            ENC_S: begin
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                range_bad = !fits12;
            end
            // Inverse of the team's B-type decoder, not the ISA's standard B layout.
            ENC_B: begin
                enc_word  = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3,
                             in_imm[3:0], in_imm[10], in_opcode};
                range_bad = !fits12;
            end
            ENC_U: begin
                enc_word  = {in_imm[31:12], in_rd, in_opcode};
                range_bad = (in_imm[11:0] != 12'd0);
            end
            ENC_J: begin
                enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                range_bad = !fits21 || in_imm[0];
            end
            default: enc_legal = 1'b0;
        endcase
    end

    assign in_ready   = (state == LOAD) && (accepted < DEPTH_W) && !finish_seen;
    assign accept     = in_valid && in_ready;
    assign write_new  = accept && enc_legal;
    assign start_load = start && (state != LOAD);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            // A write in flight this cycle completes at this edge; only a new legal accept holds LOAD.
            LOAD: if ((finish || finish_seen || accepted == DEPTH_W) && !write_new) state_next = DONE;
            DONE: if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            accepted    <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            finish_seen <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            enc_err_q   <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            we_q <= write_new;
            if (write_new) wdata_q <= enc_word;
            if (start_load) begin
                accepted    <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                finish_seen <= 1'b0;
                enc_err_q   <= 1'b0;
                range_err_q <= 1'b0;
            end else begin
                if (we_q) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    count  <= count + 1'b1;
                end
                if (accept) begin
                    accepted <= accepted + 1'b1;
                    if (!enc_legal)     enc_err_q   <= 1'b1;
                    else if (range_bad) range_err_q <= 1'b1;
                end
                if (state == LOAD && finish) finish_seen <= 1'b1;
            end
        end
    end

    assign imem_we       = we_q;
    assign imem_addr     = wr_ptr;
    assign imem_wdata    = wdata_q;
    assign busy          = (state == LOAD);
    assign done          = (state == DONE);
    assign words_written = count;
    assign enc_err       = enc_err_q;
    assign range_err     = range_err_q;

endmodule
